// File: rtl/reg_univ_if.sv
// Operation/data bundle for reg_univ: control, serial inputs, register contents and flags.
// master drives the operation inputs and observes the result; slave is the register itself.
interface reg_univ_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic             clr;
    logic [2:0]       mode;
    logic [WIDTH-1:0] Reg_In;
    logic             ser_l;
    logic             ser_r;
    logic [WIDTH-1:0] Reg_Out;
    logic             carry;
    logic             zero;

    // No handshake: every rising edge with EN=1 (or clr=1) consumes the inputs,
    // and the result plus flags are valid from that edge until the next update.
    modport master (
        output EN, clr, mode, Reg_In, ser_l, ser_r,
        input  Reg_Out, carry, zero
    );

    modport slave (
        input  EN, clr, mode, Reg_In, ser_l, ser_r,
        output Reg_Out, carry, zero
    );
endinterface

// File: rtl/reg_univ.sv
// Universal register: load, shift, rotate, inc/dec, clear, with registered carry and zero flags.
// Define REG_UNIV_SAT_EN to make INC/DEC saturate at the ends of the range instead of wrapping.
module reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       res,
    reg_univ_if.slave  bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] q;
    logic             c_q;
    logic             z_q;
    logic [WIDTH-1:0] q_next;
    logic             c_next;
    logic [WIDTH:0]   inc_full;
    logic [WIDTH:0]   dec_full;

    assign op       = mode_e'(bus.mode);
    // Top bit of the extended result is the carry out (INC) or borrow (DEC).
    assign inc_full = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_full = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_next = q;
        c_next = c_q;
        case (op)
            M_HOLD: begin
                q_next = q;
                c_next = c_q;
            end
            M_LOAD: begin
                q_next = bus.Reg_In;
                c_next = 1'b0;
            end
            M_SHL: begin
                q_next = {q[WIDTH-2:0], bus.ser_r};
                c_next = q[WIDTH-1];
            end
            M_SHR: begin
                q_next = {bus.ser_l, q[WIDTH-1:1]};
                c_next = q[0];
            end
            M_ROL: begin
                q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                c_next = q[WIDTH-1];
            end
            M_ROR: begin
                q_next = {q[0], q[WIDTH-1:1]};
                c_next = q[0];
            end
            M_INC: begin
                c_next = inc_full[WIDTH];
`ifdef REG_UNIV_SAT_EN
                q_next = inc_full[WIDTH] ? q : inc_full[WIDTH-1:0];
`else
                q_next = inc_full[WIDTH-1:0];
`endif
            end
            M_DEC: begin
                c_next = dec_full[WIDTH];
`ifdef REG_UNIV_SAT_EN
                q_next = dec_full[WIDTH] ? q : dec_full[WIDTH-1:0];
`else
                q_next = dec_full[WIDTH-1:0];
`endif
            end
            default: begin
                q_next = q;
                c_next = c_q;
            end
        endcase
    end

    // zero is computed from q_next so it lands on the same edge as the data.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q   <= RESET_VAL;
            c_q <= 1'b0;
            z_q <= (RESET_VAL == '0);
        end else if (bus.clr) begin
            q   <= '0;
            c_q <= 1'b0;
            z_q <= 1'b1;
        end else if (bus.EN) begin
            q   <= q_next;
            c_q <= c_next;
            z_q <= (q_next == '0);
        end
    end

    assign bus.Reg_Out = q;
    assign bus.carry   = c_q;
    assign bus.zero    = z_q;
endmodule

// File: tb/tb_reg_univ.sv
// Directed bench for reg_univ (WIDTH=8, RESET_VAL=8'hA5); expectations follow REG_UNIV_SAT_EN.
module tb_reg_univ;
    localparam int         W   = 8;
    localparam logic [W-1:0] RV = 8'hA5;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

    logic clk;
    logic res;
    int   n_checks;
    int   n_fail;

    reg_univ_if #(.WIDTH(W)) bus ();

    reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation, let one rising edge sample it, then settle 1 time unit.
    task automatic step(input logic en, input logic c, input logic [2:0] m,
                        input logic [W-1:0] d, input logic sl, input logic sr);
        bus.EN     = en;
        bus.clr    = c;
        bus.mode   = m;
        bus.Reg_In = d;
        bus.ser_l  = sl;
        bus.ser_r  = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+1:0] got;
        res = 1'b0;
        bus.EN = 1'b0; bus.clr = 1'b0; bus.mode = HOLD;
        bus.Reg_In = '0; bus.ser_l = 1'b0; bus.ser_r = 1'b0;
        #12;
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial: got q=%h c=%b z=%b, want q=%h c=0 z=0", got[W+1:2], got[1], got[0], RV);
        end
        res = 1'b1;
        step(1'b1, 1'b0, LOAD, 8'h33, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h33, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_33: got q=%h c=%b z=%b, want q=33 c=0 z=0", got[W+1:2], got[1], got[0]);
        end
        #3;
        res = 1'b0;
        #1;
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got q=%h c=%b z=%b, want q=%h c=0 z=0", got[W+1:2], got[1], got[0], RV);
        end
        #1;
        res = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, INC, 8'hFF, 1'b1, 1'b1);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold_en0: got q=%h c=%b z=%b, want q=%h c=0 z=0", got[W+1:2], got[1], got[0], RV);
        end
    endtask

    task automatic test_load_shift();
        logic [W-1:0] exp_q [6];
        logic         exp_c [6];
        logic [2:0]   ops   [6];
        logic         sls   [6];
        logic [W+1:0] got;
        ops = '{LOAD, SHL, SHR, ROR, ROL, HOLD};
        sls = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q = '{8'h81, 8'h02, 8'h81, 8'hC0, 8'h81, 8'h81};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            // ser_r is held 0 so SHL shifts a zero in; ser_l follows the table.
            step(1'b1, 1'b0, ops[i], 8'h81, sls[i], 1'b0);
            got = {bus.Reg_Out, bus.carry, bus.zero};
            n_checks++;
            if (got !== {exp_q[i], exp_c[i], 1'b0}) begin
                n_fail++;
                $display("FAIL shift_step%0d: got q=%h c=%b z=%b, want q=%h c=%b z=0", i, got[W+1:2], got[1], got[0], exp_q[i], exp_c[i]);
            end
        end
        step(1'b1, 1'b0, SHL, 8'h00, 1'b0, 1'b1);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h03, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL shl_ser_r1: got q=%h c=%b z=%b, want q=03 c=1 z=0", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b0, LOAD, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_zero_clears_carry: got q=%h c=%b z=%b, want q=00 c=0 z=1", got[W+1:2], got[1], got[0]);
        end
    endtask

    task automatic test_count();
        logic [W+1:0] got;
        logic [W+1:0] want;
        step(1'b1, 1'b0, LOAD, 8'hFE, 1'b0, 1'b0);
        step(1'b1, 1'b0, INC, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_fe: got q=%h c=%b z=%b, want q=ff c=0 z=0", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b0, INC, 8'h00, 1'b0, 1'b0);
`ifdef REG_UNIV_SAT_EN
        want = {8'hFF, 1'b1, 1'b0};
`else
        want = {8'h00, 1'b1, 1'b1};
`endif
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL inc_ff: got q=%h c=%b z=%b, want q=%h c=%b z=%b", got[W+1:2], got[1], got[0], want[W+1:2], want[1], want[0]);
        end
    endtask

    task automatic test_borrow();
        logic [W+1:0] got;
        logic [W+1:0] want;
        step(1'b1, 1'b0, LOAD, 8'h01, 1'b0, 1'b0);
        step(1'b1, 1'b0, DEC, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL dec_01: got q=%h c=%b z=%b, want q=00 c=0 z=1", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b0, DEC, 8'h00, 1'b0, 1'b0);
`ifdef REG_UNIV_SAT_EN
        want = {8'h00, 1'b1, 1'b1};
`else
        want = {8'hFF, 1'b1, 1'b0};
`endif
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL dec_00: got q=%h c=%b z=%b, want q=%h c=%b z=%b", got[W+1:2], got[1], got[0], want[W+1:2], want[1], want[0]);
        end
    endtask

    task automatic test_priority();
        logic [W+1:0] got;
        step(1'b1, 1'b0, LOAD, 8'h9E, 1'b0, 1'b0);
        step(1'b1, 1'b0, SHL, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h3C, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_setup: got q=%h c=%b z=%b, want q=3c c=1 z=0", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b1, LOAD, 8'h55, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_over_load: got q=%h c=%b z=%b, want q=00 c=0 z=1", got[W+1:2], got[1], got[0]);
        end
        step(1'b0, 1'b0, INC, 8'h55, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL en0_after_clr: got q=%h c=%b z=%b, want q=00 c=0 z=1", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b0, LOAD, 8'h80, 1'b0, 1'b0);
        step(1'b1, 1'b0, ROL, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, INC, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_with_en0: got q=%h c=%b z=%b, want q=00 c=0 z=1", got[W+1:2], got[1], got[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+1:0] got;
        step(1'b1, 1'b0, LOAD, 8'h10, 1'b0, 1'b0);
        step(1'b1, 1'b0, INC, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'h11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_10: got q=%h c=%b z=%b, want q=11 c=0 z=0", got[W+1:2], got[1], got[0]);
        end
        #3;
        res = 1'b0;
        #1;
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_inc: got q=%h c=%b z=%b, want q=%h c=0 z=0", got[W+1:2], got[1], got[0], RV);
        end
        // Reset held across an enabled edge must still win.
        @(posedge clk);
        #1;
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held_edge: got q=%h c=%b z=%b, want q=%h c=0 z=0", got[W+1:2], got[1], got[0], RV);
        end
        #3;
        res = 1'b1;
        @(posedge clk);
        #1;
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'hA6, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL resume_after_reset: got q=%h c=%b z=%b, want q=a6 c=0 z=0", got[W+1:2], got[1], got[0]);
        end
        step(1'b1, 1'b0, INC, 8'h00, 1'b0, 1'b0);
        got = {bus.Reg_Out, bus.carry, bus.zero};
        n_checks++;
        if (got !== {8'hA7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL resume_second_inc: got q=%h c=%b z=%b, want q=a7 c=0 z=0", got[W+1:2], got[1], got[0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_shift();
        test_count();
        test_borrow();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_univ.md
Name: reg_univ

Overview:
- Parametrised universal register; next generation of the fixed 8-bit/4-bit enable registers.
- Adds per-cycle operation select:
  - parallel load
  - logical shift left/right with serial inputs
  - rotate left/right
  - increment and decrement
  - synchronous clear
- Adds registered carry and zero flags.
- Used as datapath accumulator, shift register or loop counter in the processor datapath.

Parameters:
WIDTH, 8, data width in bits (minimum 2)
RESET_VAL, 0, value loaded into Reg_Out on asynchronous reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
res  input  1  asynchronous active-low reset
EN  input  1  operation enable; 0 = hold everything
clr  input  1  synchronous clear, priority over EN and mode
mode  input  3  operation select (see Behaviour)
Reg_In  input  WIDTH  parallel load data
ser_l  input  1  serial bit entering MSB on SHR
ser_r  input  1  serial bit entering LSB on SHL
Reg_Out  output  WIDTH  register contents
carry  output  1  registered carry/shift-out flag
zero  output  1  registered flag, 1 when Reg_Out == 0

Behaviour:
- Reset (res low, asynchronous, no clock needed):
  - Reg_Out = RESET_VAL
  - carry = 0
  - zero = (RESET_VAL == 0)
  - Reset held low overrides all inputs. Reset asserted mid-operation discards the pending update.
- All non-reset updates on the rising clk edge. Latency is 1 cycle: the result and flags are visible after the edge where the operation is sampled.
- Priority: res > clr > EN.
  - clr=1: Reg_Out = 0, carry = 0, zero = 1, regardless of EN and mode.
  - clr=0, EN=0: Reg_Out, carry and zero hold.
- With clr=0, EN=1, mode selects the operation (q = Reg_Out):
  - 000 HOLD: q, carry and zero unchanged (zero still consistent with q).
  - 001 LOAD: q <= Reg_In; carry <= 0.
  - 010 SHL: q <= {q[W-2:0], ser_r}; carry <= q[W-1].
  - 011 SHR: q <= {ser_l, q[W-1:1]}; carry <= q[0].
  - 100 ROL: q <= {q[W-2:0], q[W-1]}; carry <= q[W-1].
  - 101 ROR: q <= {q[0], q[W-1:1]}; carry <= q[0].
  - 110 INC: q <= q+1 modulo 2^W; carry <= 1 iff q was all-ones, else 0.
  - 111 DEC: q <= q-1 modulo 2^W; carry (borrow) <= 1 iff q was 0, else 0.
- zero is registered from the next value of q in the same edge, so it never lags Reg_Out.
- All arithmetic is unsigned, WIDTH bits; the carry is the (WIDTH+1)th bit of the result.
- No undefined modes; every 3-bit code is listed above.

Optional Feature:
- Macro: REG_UNIV_SAT_EN.
- Defined:
  - INC at all-ones keeps q all-ones and sets carry=1.
  - DEC at 0 keeps q=0 and sets carry=1.
  - All other modes unchanged.
- Not defined: INC/DEC wrap modulo 2^W as described in Behaviour.

Test Plan:
- Reset value: WIDTH=8, RESET_VAL=8'hA5; pull res low asynchronously between clock edges -> Reg_Out=A5, carry=0, zero=0 immediately, without a clock edge. Release res, EN=0 for 3 edges -> values hold.
- Load and shifts: LOAD 8'h81, then SHL with ser_r=0 -> 02, carry=1. Then SHR with ser_l=1 -> 81, carry=0. Then ROR -> C0, carry=1. Then ROL -> 81, carry=1.
- Counting:
  - LOAD FE, INC, INC -> FF (carry=0), then 00 with carry=1, zero=1 (without REG_UNIV_SAT_EN).
  - With REG_UNIV_SAT_EN: second INC gives FF, carry=1, zero=0.
- Borrow: LOAD 01, DEC, DEC -> 00 (zero=1, carry=0), then FF with carry=1 (without macro); with macro, 00 with carry=1.
- Priority: Reg_Out=3C; assert clr=1 together with EN=1, mode=LOAD, Reg_In=55 -> Reg_Out=00, zero=1, carry=0. Next cycle, EN=0 with mode=INC -> stays 00.
- Reset mid-operation: Reg_Out=10, INC active every cycle; assert res low mid-cycle -> Reg_Out=RESET_VAL at once. On release, counting resumes from RESET_VAL on the first enabled edge.
